// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB/BRANCH/JUMP sequencing with a
// memory-wait watchdog that parks the machine in HALT with a sticky memError.
module multicycle_control #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       irWrite,
  output logic       memRead,
  output logic       memWrite,
  output logic       regWrite,
  output logic       iorD,
  output logic       memToReg,
  output logic       regDst,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic       branchTaken,
  output logic       illegalOp,
  output logic       memError,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

  localparam int            CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [5:0]    op_q, op_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          merr_q, merr_d;

  logic       pcw_c, irw_c, mrd_c, mwr_c, rgw_c, iord_c, m2r_c, rdst_c, srca_c;
  logic [1:0] srcb_c, aluop_c, pcsrc_c;
  logic       taken_c, illegal_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      merr_q  <= merr_d;
    end
  end

  // memReady is a level handshake: the access in FETCH/MEM completes in the cycle it is 1;
  // each cycle it stays 0 is a wait cycle, and the counter only survives while the state holds.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wait_d    = '0;
    merr_d    = merr_q;
    pcw_c     = 1'b0;
    irw_c     = 1'b0;
    mrd_c     = 1'b0;
    mwr_c     = 1'b0;
    rgw_c     = 1'b0;
    iord_c    = 1'b0;
    m2r_c     = 1'b0;
    rdst_c    = 1'b0;
    srca_c    = 1'b0;
    srcb_c    = 2'b00;
    aluop_c   = 2'b00;
    pcsrc_c   = 2'b00;
    taken_c   = 1'b0;
    illegal_c = 1'b0;

    case (state_q)
      S_FETCH: begin
        mrd_c  = 1'b1;
        srcb_c = 2'b01;
        if (memReady) begin
          irw_c   = 1'b1;
          pcw_c   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
          merr_d  = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        srcb_c = 2'b11;
        op_d   = opcode;
        case (opcode)
          OP_R, OP_LW, OP_SW: state_d = S_EXEC;
          OP_BEQ, OP_BNE:     state_d = S_BRANCH;
          OP_J:               state_d = S_JUMP;
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        srca_c = 1'b1;
        if (op_q == OP_R) begin
          aluop_c = 2'b10;
          state_d = S_WB;
        end else begin
          srcb_c  = 2'b10;
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        iord_c = 1'b1;
        mrd_c  = (op_q == OP_LW);
        mwr_c  = (op_q == OP_SW);
        if (memReady) begin
          state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
          merr_d  = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        rgw_c = 1'b1;
        if (op_q == OP_R) rdst_c = 1'b1;
        else              m2r_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        srca_c  = 1'b1;
        aluop_c = 2'b01;
        pcsrc_c = 2'b01;
        taken_c = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);
        pcw_c   = taken_c;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pcsrc_c = 2'b10;
        pcw_c   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset also masks the FETCH-state decode so nothing reaches memory while rst_n is low.
  assign pcWrite     = rst_n & pcw_c;
  assign irWrite     = rst_n & irw_c;
  assign memRead     = rst_n & mrd_c;
  assign memWrite    = rst_n & mwr_c;
  assign regWrite    = rst_n & rgw_c;
  assign iorD        = rst_n & iord_c;
  assign memToReg    = rst_n & m2r_c;
  assign regDst      = rst_n & rdst_c;
  assign aluSrcA     = rst_n & srca_c;
  assign aluSrcB     = {2{rst_n}} & srcb_c;
  assign aluOp       = {2{rst_n}} & aluop_c;
  assign pcSource    = {2{rst_n}} & pcsrc_c;
  assign branchTaken = rst_n & taken_c;
  assign illegalOp   = rst_n & illegal_c;
  assign memError    = merr_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each instruction class walked cycle by cycle
// against hand-computed state and control values, plus watchdog and reset cases.
module tb_multicycle_control;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

  logic       clk, rst_n;
  logic [5:0] opcode;
  logic       zero, memReady;
  logic       pcWrite, irWrite, memRead, memWrite, regWrite, iorD, memToReg, regDst, aluSrcA;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic       branchTaken, illegalOp, memError;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  multicycle_control #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .memReady(memReady),
    .pcWrite(pcWrite), .irWrite(irWrite), .memRead(memRead), .memWrite(memWrite),
    .regWrite(regWrite), .iorD(iorD), .memToReg(memToReg), .regDst(regDst),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSource(pcSource),
    .branchTaken(branchTaken), .illegalOp(illegalOp), .memError(memError), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic [2:0] st, input logic pcw, input logic irw,
                     input logic mrd, input logic mwr, input logic rgw);
    chk({tag, "_state"}, 8'(state), 8'(st));
    chk({tag, "_pcWrite"}, 8'(pcWrite), 8'(pcw));
    chk({tag, "_irWrite"}, 8'(irWrite), 8'(irw));
    chk({tag, "_memRead"}, 8'(memRead), 8'(mrd));
    chk({tag, "_memWrite"}, 8'(memWrite), 8'(mwr));
    chk({tag, "_regWrite"}, 8'(regWrite), 8'(rgw));
  endtask

  initial begin
    rst_n = 1'b0; opcode = OP_R; zero = 1'b0; memReady = 1'b0;
    smp();
    ctl("rst", 3'd0, 0, 0, 0, 0, 0);
    chk("rst_memError", 8'(memError), 8'd0);
    chk("rst_aluSrcB", 8'(aluSrcB), 8'd0);
    step();
    rst_n = 1'b1;

    // R-type, opcode input changed after DECODE to prove the latched copy is used
    memReady = 1'b1;
    smp(); ctl("r_fetch", 3'd0, 1, 1, 1, 0, 0); chk("r_fetch_srcb", 8'(aluSrcB), 8'd1); step();
    smp(); ctl("r_dec", 3'd1, 0, 0, 0, 0, 0); chk("r_dec_srcb", 8'(aluSrcB), 8'd3); step();
    opcode = OP_LW;
    smp(); ctl("r_exec", 3'd2, 0, 0, 0, 0, 0);
    chk("r_exec_srca", 8'(aluSrcA), 8'd1); chk("r_exec_aluop", 8'(aluOp), 8'd2);
    chk("r_exec_srcb", 8'(aluSrcB), 8'd0); step();
    smp(); ctl("r_wb", 3'd4, 0, 0, 0, 0, 1);
    chk("r_wb_regdst", 8'(regDst), 8'd1); chk("r_wb_m2r", 8'(memToReg), 8'd0); step();

    // BEQ taken, preceded by one FETCH stall
    opcode = OP_BEQ; zero = 1'b1; memReady = 1'b0;
    smp(); ctl("beq_stall", 3'd0, 0, 0, 1, 0, 0); step();
    memReady = 1'b1;
    smp(); ctl("beq_fetch", 3'd0, 1, 1, 1, 0, 0); step();
    smp(); chk("beq_dec_state", 8'(state), 8'd1); step();
    smp(); ctl("beq_br", 3'd5, 1, 0, 0, 0, 0);
    chk("beq_taken", 8'(branchTaken), 8'd1); chk("beq_pcsrc", 8'(pcSource), 8'd1);
    chk("beq_aluop", 8'(aluOp), 8'd1); step();

    // BNE with zero=1: not taken
    opcode = OP_BNE;
    smp(); chk("bne1_fetch_state", 8'(state), 8'd0); step();
    smp(); step();
    smp(); ctl("bne1_br", 3'd5, 0, 0, 0, 0, 0);
    chk("bne1_taken", 8'(branchTaken), 8'd0); chk("bne1_pcsrc", 8'(pcSource), 8'd1); step();

    // BNE with zero=0: taken
    zero = 1'b0;
    smp(); step(); smp(); step();
    smp(); chk("bne0_state", 8'(state), 8'd5); chk("bne0_pcw", 8'(pcWrite), 8'd1);
    chk("bne0_taken", 8'(branchTaken), 8'd1); step();

    // J
    opcode = OP_J;
    smp(); chk("j_fetch_state", 8'(state), 8'd0); step();
    smp(); step();
    smp(); ctl("j_jump", 3'd6, 1, 0, 0, 0, 0); chk("j_pcsrc", 8'(pcSource), 8'd2); step();
    smp(); chk("j_back_state", 8'(state), 8'd0);

    // LW with two MEM wait cycles: F,D,E,M,M,M,WB; zero toggled to show it is ignored
    opcode = OP_LW; zero = 1'b1; step();
    smp(); chk("lw_dec_state", 8'(state), 8'd1); step();
    smp(); chk("lw_exec_state", 8'(state), 8'd2); chk("lw_exec_srcb", 8'(aluSrcB), 8'd2);
    chk("lw_exec_srca", 8'(aluSrcA), 8'd1); step();
    memReady = 1'b0; zero = 1'b0;
    smp(); ctl("lw_mem1", 3'd3, 0, 0, 1, 0, 0); chk("lw_mem1_iord", 8'(iorD), 8'd1); step();
    smp(); chk("lw_mem2_state", 8'(state), 8'd3); step();
    memReady = 1'b1;
    smp(); ctl("lw_mem3", 3'd3, 0, 0, 1, 0, 0); step();
    smp(); ctl("lw_wb", 3'd4, 0, 0, 0, 0, 1);
    chk("lw_wb_m2r", 8'(memToReg), 8'd1); chk("lw_wb_regdst", 8'(regDst), 8'd0); step();
    smp(); chk("lw_done_state", 8'(state), 8'd0);

    // Illegal opcode: one-cycle illegalOp pulse in DECODE, back to FETCH
    opcode = 6'b111111; step();
    smp(); chk("ill_dec_state", 8'(state), 8'd1); chk("ill_pulse", 8'(illegalOp), 8'd1); step();
    smp(); chk("ill_back_state", 8'(state), 8'd0); chk("ill_clear", 8'(illegalOp), 8'd0);

    // SW, reset pulsed during MEM
    opcode = OP_SW; step();
    smp(); chk("sw_dec_state", 8'(state), 8'd1); step();
    smp(); chk("sw_exec_state", 8'(state), 8'd2); step();
    memReady = 1'b0;
    smp(); ctl("sw_mem", 3'd3, 0, 0, 0, 1, 0); chk("sw_mem_iord", 8'(iorD), 8'd1);
    #1 rst_n = 1'b0;
    #1 chk("sw_rst_memWrite", 8'(memWrite), 8'd0); chk("sw_rst_state", 8'(state), 8'd0);
    chk("sw_rst_iord", 8'(iorD), 8'd0);
    step();
    rst_n = 1'b1;

    // Watchdog: 15 wait cycles in FETCH, then HALT with sticky memError
    for (int i = 1; i <= 15; i++) begin
      smp();
      chk($sformatf("to_wait%0d_state", i), 8'(state), 8'd0);
      chk($sformatf("to_wait%0d_merr", i), 8'(memError), 8'd0);
      step();
    end
    smp(); chk("to_halt_state", 8'(state), 8'd7); chk("to_halt_merr", 8'(memError), 8'd1);
    chk("to_halt_memRead", 8'(memRead), 8'd0);
    memReady = 1'b1; step(); step();
    smp(); ctl("to_hold", 3'd7, 0, 0, 0, 0, 0); chk("to_hold_merr", 8'(memError), 8'd1);
    #1 rst_n = 1'b0;
    #1 chk("to_rst_state", 8'(state), 8'd0); chk("to_rst_merr", 8'(memError), 8'd0);
    step();
    rst_n = 1'b1;
    smp(); ctl("post_rst", 3'd0, 1, 1, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
